tow_game_ctrl: RTL and testbench
================================

Name: tow_game_ctrl

Overview:
Round sequencer for the Tug of War game. It drives the push-button latch block's clear input to open and close each round. It samples the latch's push/tie/right results and moves a one-hot rope position across the LED bar. It detects a win at either end. A random pause between rounds comes from an LFSR, so neither player can anticipate the arming instant.

Parameters:
NUM_LEDS, 9, LED bar length; odd, >= 3; centre index = (NUM_LEDS-1)/2
DELAY_MIN, 16'd1000, minimum DELAY length in clk cycles; >= 1
DELAY_MASK, 16'h03FF, AND-mask applied to the LFSR to form the random extra delay
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
new_game  input  1  synchronous pulse: start or restart a game
push  input  1  from button latch: a player has latched
tie  input  1  from button latch: both players latched
right  input  1  from button latch: right player latched
clear  output  1  to button latch: holds both latches cleared while 1
leds  output  NUM_LEDS  one-hot rope position; higher index = toward right player
winner_valid  output  1  game over, winner decided
winner_right  output  1  valid when winner_valid: 1 = right won, 0 = left won

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pos=centre, lfsr=LFSR_SEED, dly_cnt=0
  - winner_valid=0, winner_right=0
  - clear=1, leds=one-hot(centre)
- clear decode: clear is a combinational decode of state; 1 in every state except ARMED.
- leds: always one-hot(pos); pos width is clog2(NUM_LEDS).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in all states except reset.
- Delay value: D = DELAY_MIN + (lfsr & DELAY_MASK), 16-bit unsigned, sampled on the edge entering DELAY. D must not overflow; configurations that overflow are illegal.
- State machine:
  - IDLE: waits. new_game=1 -> DELAY; pos=centre; load D.
  - DELAY: counts down. ARMED is entered exactly D cycles after DELAY is entered. push/tie/right are ignored.
  - ARMED: clear=0. On the first edge with push=1:
    - tie=1 -> pos unchanged
    - else right=1 -> pos+1
    - else -> pos-1
    - next state RESOLVE
  - RESOLVE: exactly one cycle, clear=1.
    - pos==NUM_LEDS-1 -> WON; winner_valid=1, winner_right=1
    - pos==0 -> WON; winner_valid=1, winner_right=0
    - otherwise -> DELAY; load new D
  - WON: clear=1; pos frozen; inputs ignored. new_game -> DELAY; pos=centre; winner_valid=0; load D.
- new_game in DELAY, ARMED or RESOLVE aborts the round: -> DELAY, pos=centre, load D. new_game has priority over push in the same cycle.
- Latency: push sampled at edge k in ARMED -> leds updated and clear=1 after edge k. Win flags assert after edge k+1.
- pos never leaves 0..NUM_LEDS-1. A move away from centre only happens in ARMED, and an end position always exits to WON.
- Reset mid-operation:
  - takes effect immediately, regardless of clk
  - clear=1 at once, so any latched press is discarded
  - on release, stays in IDLE until new_game

Test Plan:
1. Config NUM_LEDS=5, DELAY_MIN=4, DELAY_MASK=0. Hold rst=0 -> leds=5'b00100, clear=1, winner_valid=0. Release rst, no new_game for 50 cycles -> still IDLE, clear=1.
2. Pulse new_game -> clear=1 for exactly 4 cycles, then 0. Drive push=1, right=1 -> next edge leds=5'b01000, clear=1 for 1 RESOLVE cycle plus 4 DELAY cycles, then clear=0 again.
3. In ARMED drive push=1, tie=1 -> leds unchanged (5'b00100); new round armed 5 cycles later. Separately, push=1, right=0 -> leds=5'b00010.
4. Two consecutive right wins from centre -> leds=5'b10000. One cycle later winner_valid=1, winner_right=1, clear=1. Further push pulses change nothing. new_game -> leds=5'b00100, winner_valid=0. Repeat with two left wins -> leds=5'b00001, winner_right=0.
5. Abort and reset mid-round:
   - push held 1 throughout DELAY -> no move until ARMED.
   - Assert rst=0 mid-clock while in ARMED -> clear=1 and leds=centre before the next edge.
   - new_game and push in the same ARMED cycle -> pos=centre, state DELAY.
6. DELAY_MASK=3, run 32 rounds -> every DELAY length lies in 4..7, and at least 3 distinct lengths are observed.

Source files
------------

// File: rtl/tow_game_ctrl.sv
// tow_game_ctrl: round sequencer for the Tug of War game.
// Opens and closes each round through the button latch's clear input, moves a
// one-hot rope position along the LED bar from the latch's push/tie/right
// results, and flags a winner when the rope reaches either end. The pause
// between rounds is DELAY_MIN plus a masked LFSR value, so the arming instant
// cannot be anticipated.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   new_game     synchronous pulse: start or restart a game
//   push         button latch: a player has latched
//   tie          button latch: both players latched
//   right        button latch: right player latched
//   clear        to button latch: holds both latches cleared while 1
//   leds         one-hot rope position, higher index toward right player
//   winner_valid game over, winner decided
//   winner_right 1 = right won, 0 = left won (meaningful with winner_valid)
//
// state   | meaning
// IDLE    | after reset, waiting for new_game
// DELAY   | random pause, latches held cleared
// ARMED   | latches released, waiting for the first press
// RESOLVE | one cycle to check for a win after a move
// WON     | game over, position frozen until new_game

module tow_game_ctrl #(
  parameter int unsigned NUM_LEDS   = 9,
  parameter logic [15:0] DELAY_MIN  = 16'd1000,
  parameter logic [15:0] DELAY_MASK = 16'h03FF,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_game,
  input  logic                push,
  input  logic                tie,
  input  logic                right,
  output logic                clear,
  output logic [NUM_LEDS-1:0] leds,
  output logic                winner_valid,
  output logic                winner_right
);

  localparam int unsigned  PW     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [PW-1:0] CENTRE = PW'((NUM_LEDS - 1) / 2);
  localparam logic [PW-1:0] LAST   = PW'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_ARMED,
    S_RESOLVE,
    S_WON
  } state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [15:0]   lfsr;
  logic [15:0]   dly_cnt;
  logic [15:0]   dly_load;
  logic          lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // The counter holds the cycles remaining after the entry edge, so ARMED is
  // reached exactly D edges after DELAY is entered.
  assign dly_load = DELAY_MIN + (lfsr & DELAY_MASK) - 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      pos          <= CENTRE;
      lfsr         <= LFSR_SEED;
      dly_cnt      <= '0;
      winner_valid <= 1'b0;
      winner_right <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      // new_game restarts from any state and outranks a press in ARMED.
      if (new_game) begin
        state        <= S_DELAY;
        pos          <= CENTRE;
        dly_cnt      <= dly_load;
        winner_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_DELAY: begin
            if (dly_cnt == '0) state <= S_ARMED;
            else               dly_cnt <= dly_cnt - 16'd1;
          end
          S_ARMED: begin
            if (push) begin
              // pos is never an end value here: ends always exit to WON.
              if (!tie) pos <= right ? pos + PW'(1) : pos - PW'(1);
              state <= S_RESOLVE;
            end
          end
          S_RESOLVE: begin
            if (pos == LAST) begin
              state        <= S_WON;
              winner_valid <= 1'b1;
              winner_right <= 1'b1;
            end else if (pos == '0) begin
              state        <= S_WON;
              winner_valid <= 1'b1;
              winner_right <= 1'b0;
            end else begin
              state   <= S_DELAY;
              dly_cnt <= dly_load;
            end
          end
          S_WON: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign clear = (state != S_ARMED);
  assign leds  = NUM_LEDS'(1) << pos;

endmodule

// File: tb/tb_tow_game_ctrl.sv
module tb_tow_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       new_game = 1'b0, push = 1'b0, tie = 1'b0, right = 1'b0;
  logic       clear, winner_valid, winner_right;
  logic [4:0] leds;

  logic       ng2 = 1'b0, push2 = 1'b0, tie2 = 1'b0, right2 = 1'b0;
  logic       clear2, wv2, wr2;
  logic [4:0] leds2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tow_game_ctrl #(
    .NUM_LEDS(5), .DELAY_MIN(16'd4), .DELAY_MASK(16'h0000), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .push(push), .tie(tie),
    .right(right), .clear(clear), .leds(leds),
    .winner_valid(winner_valid), .winner_right(winner_right)
  );

  tow_game_ctrl #(
    .NUM_LEDS(5), .DELAY_MIN(16'd4), .DELAY_MASK(16'h0003), .LFSR_SEED(16'hACE1)
  ) dut_rnd (
    .clk(clk), .rst(rst), .new_game(ng2), .push(push2), .tie(tie2),
    .right(right2), .clear(clear2), .leds(leds2),
    .winner_valid(wv2), .winner_right(wr2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  task automatic do_push(input logic t, input logic r);
    push = 1'b1; tie = t; right = r;
    tick();
    push = 1'b0; tie = 1'b0; right = 1'b0;
  endtask

  // Counts post-edge samples with clear=1 until the design arms (bounded).
  task automatic arm_wait(input logic sel, output int n);
    n = 0;
    while ((sel ? clear2 : clear) && n < 200) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int d;
    int distinct;
    logic [15:0] seen;

    // 1: reset and idle
    repeat (3) tick();
    check("rst_leds", leds, 5'b00100);
    check("rst_clear", clear, 1'b1);
    check("rst_wv", winner_valid, 1'b0);
    rst = 1'b1;
    repeat (50) tick();
    check("idle_clear", clear, 1'b1);
    check("idle_leds", leds, 5'b00100);

    // 2: first round, right move
    start();
    arm_wait(1'b0, n);
    check("first_delay", n, 4);
    do_push(1'b0, 1'b1);
    check("right_leds", leds, 5'b01000);
    check("right_clear", clear, 1'b1);
    arm_wait(1'b0, n);
    check("resolve_delay", n, 5);

    // 3: tie, then left move
    start();
    arm_wait(1'b0, n);
    check("restart_delay", n, 4);
    do_push(1'b1, 1'b1);
    check("tie_leds", leds, 5'b00100);
    arm_wait(1'b0, n);
    check("tie_rearm", n, 5);
    do_push(1'b0, 1'b0);
    check("left_leds", leds, 5'b00010);
    arm_wait(1'b0, n);
    check("left_rearm", n, 5);

    // 4: right win, then left win
    start();
    arm_wait(1'b0, n);
    do_push(1'b0, 1'b1);
    arm_wait(1'b0, n);
    do_push(1'b0, 1'b1);
    check("rwin_leds", leds, 5'b10000);
    check("rwin_wv_early", winner_valid, 1'b0);
    tick();
    check("rwin_wv", winner_valid, 1'b1);
    check("rwin_wr", winner_right, 1'b1);
    check("rwin_clear", clear, 1'b1);
    repeat (3) begin
      do_push(1'b0, 1'b0);
      tick();
    end
    check("won_frozen_leds", leds, 5'b10000);
    check("won_frozen_wv", winner_valid, 1'b1);
    check("won_frozen_clear", clear, 1'b1);
    start();
    check("ng_leds", leds, 5'b00100);
    check("ng_wv", winner_valid, 1'b0);
    arm_wait(1'b0, n);
    check("ng_delay", n, 4);
    do_push(1'b0, 1'b0);
    arm_wait(1'b0, n);
    do_push(1'b0, 1'b0);
    check("lwin_leds", leds, 5'b00001);
    tick();
    check("lwin_wv", winner_valid, 1'b1);
    check("lwin_wr", winner_right, 1'b0);

    // 5a: push held through DELAY is ignored until ARMED
    push = 1'b1; right = 1'b1;
    start();
    for (int i = 0; i < 3; i++) begin
      check("held_leds", leds, 5'b00100);
      tick();
    end
    tick();
    check("held_armed_clear", clear, 1'b0);
    check("held_armed_leds", leds, 5'b00100);
    tick();
    check("held_move_leds", leds, 5'b01000);
    push = 1'b0; right = 1'b0;
    arm_wait(1'b0, n);
    check("held_rearm", n, 5);

    // 5b: asynchronous reset while ARMED
    #2 rst = 1'b0;
    #1;
    check("async_rst_clear", clear, 1'b1);
    check("async_rst_leds", leds, 5'b00100);
    tick();
    tick();
    rst = 1'b1;
    repeat (10) tick();
    check("post_rst_idle", clear, 1'b1);

    // 5c: new_game beats push in ARMED
    start();
    arm_wait(1'b0, n);
    do_push(1'b0, 1'b1);
    arm_wait(1'b0, n);
    check("pre_abort_leds", leds, 5'b01000);
    new_game = 1'b1; push = 1'b1; right = 1'b1;
    tick();
    new_game = 1'b0; push = 1'b0; right = 1'b0;
    check("abort_leds", leds, 5'b00100);
    arm_wait(1'b0, n);
    check("abort_delay", n, 4);

    // 6: random delay lengths with mask 3
    seen = '0;
    ng2 = 1'b1;
    tick();
    ng2 = 1'b0;
    arm_wait(1'b1, n);
    d = n;
    check("rnd_range", (d >= 4 && d <= 7), 1'b1);
    if (d < 16) seen[d] = 1'b1;
    for (int r = 1; r < 32; r++) begin
      push2 = 1'b1; right2 = r[0];
      tick();
      push2 = 1'b0; right2 = 1'b0;
      arm_wait(1'b1, n);
      d = n - 1;
      check("rnd_range", (d >= 4 && d <= 7), 1'b1);
      if (d >= 0 && d < 16) seen[d] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 16; i++) if (seen[i]) distinct++;
    check("rnd_distinct", (distinct >= 3), 1'b1);
    check("rnd_no_win", wv2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
